// File: rtl/mux4_arb_pkg.sv
// Shared types and sizes for the 4-way round-robin arbiter and its picker.
package mux4_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

endpackage

// File: rtl/mux4_rr_pick.sv
// Combinational round-robin picker: first active request after 'last', wrapping mod 4.
// Zero latency; no flow control of its own.
module mux4_rr_pick
    import mux4_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   last,
    output logic [SEL_W-1:0]   winner,
    output logic               any
);

    logic             found;
    logic [SEL_W-1:0] idx;

    // k=1..4 visits last+1 .. last+4 (== last), so 'last' has lowest priority.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        any    = |req;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = last + SEL_W'(k);
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving a registered select into a 4:1 data mux; grant 1 clock after request.
// Holds grant/sel/beat count while out_rdy is low; at most BURST accepted beats per grant.
module mux4_rr_arbiter
    import mux4_arb_pkg::*;
#(
    parameter int DW    = 8,
    parameter int BURST = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic [DW-1:0]      din_a,
    input  logic [DW-1:0]      din_b,
    input  logic [DW-1:0]      din_c,
    input  logic [DW-1:0]      din_d,
    input  logic               out_rdy,
    output logic [NUM_REQ-1:0] grant,
    output logic [SEL_W-1:0]   sel,
    output logic [DW-1:0]      dout,
    output logic               dout_vld
);

    localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;

    arb_state_t       state;
    logic [SEL_W-1:0] last;
    logic [CW-1:0]    beat_cnt;
    logic [SEL_W-1:0] winner;
    logic             any;
    logic             accept;
    logic             last_beat;
    logic             release_now;

    mux4_rr_pick u_pick (
        .req    (req),
        .last   (last),
        .winner (winner),
        .any    (any)
    );

    always_comb begin
        dout = din_a;
        case (sel)
            2'd0:    dout = din_a;
            2'd1:    dout = din_b;
            2'd2:    dout = din_c;
            default: dout = din_d;
        endcase
    end

    assign dout_vld    = (state == GRANT) && req[sel];
    assign accept      = dout_vld && out_rdy;
    assign last_beat   = (beat_cnt == CW'(BURST - 1));
    // A dropped request releases even under backpressure.
    assign release_now = !req[sel] || (accept && last_beat);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            grant    <= '0;
            sel      <= '0;
            beat_cnt <= '0;
            last     <= SEL_W'(NUM_REQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (any) begin
                        sel      <= winner;
                        grant    <= NUM_REQ'(1) << winner;
                        beat_cnt <= '0;
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        last     <= sel;
                        grant    <= '0;
                        beat_cnt <= '0;
                        state    <= IDLE;
                    end else if (accept) begin
                        beat_cnt <= beat_cnt + CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: directed scenarios with literal expectations plus a random run
// checked every cycle against a transaction-level owner/beats/pointer model.
module tb_mux4_rr_arbiter;

    localparam int DW    = 8;
    localparam int BURST = 4;

    logic          clk     = 1'b0;
    logic          clk_run = 1'b0;
    logic          rst     = 1'b0;
    logic [3:0]    req     = 4'b0;
    logic [DW-1:0] din_a   = '0;
    logic [DW-1:0] din_b   = '0;
    logic [DW-1:0] din_c   = '0;
    logic [DW-1:0] din_d   = '0;
    logic          out_rdy = 1'b0;
    logic [3:0]    grant;
    logic [1:0]    sel;
    logic [DW-1:0] dout;
    logic          dout_vld;

    int total = 0;
    int bad   = 0;
    logic chk_en = 1'b0;

    // Model: who owns the path (-1 = nobody), beats taken, last owner, current select.
    int m_owner = -1;
    int m_beats = 0;
    int m_last  = 3;
    int m_sel   = 0;

    mux4_rr_arbiter #(.DW(DW), .BURST(BURST)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .din_a    (din_a),
        .din_b    (din_b),
        .din_c    (din_c),
        .din_d    (din_d),
        .out_rdy  (out_rdy),
        .grant    (grant),
        .sel      (sel),
        .dout     (dout),
        .dout_vld (dout_vld)
    );

    always #5 if (clk_run) clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] din_of(input int i);
        case (i)
            0:       return din_a;
            1:       return din_b;
            2:       return din_c;
            default: return din_d;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_owner = -1;
            m_beats = 0;
            m_last  = 3;
            m_sel   = 0;
        end else if (m_owner < 0) begin
            for (int k = 1; k <= 4; k++) begin
                if (m_owner < 0 && req[(m_last + k) % 4]) begin
                    m_owner = (m_last + k) % 4;
                    m_sel   = m_owner;
                    m_beats = 0;
                end
            end
        end else begin
            if (!req[m_owner]) begin
                m_last  = m_owner;
                m_owner = -1;
            end else if (out_rdy) begin
                m_beats++;
                if (m_beats == BURST) begin
                    m_last  = m_owner;
                    m_owner = -1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("m_grant", {28'b0, grant}, (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
            check("m_sel",   {30'b0, sel},   m_sel);
            check("m_vld",   {31'b0, dout_vld}, (m_owner >= 0 && req[m_owner]) ? 32'd1 : 32'd0);
            check("m_dout",  {24'b0, dout},  {24'b0, din_of(m_sel)});
        end
    end

    task automatic reset_dut();
        @(posedge clk);
        #2;
        rst     = 1'b1;
        req     = 4'b0;
        out_rdy = 1'b0;
        #4;
        rst     = 1'b0;
    endtask

    logic [3:0] fair_exp [21] = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h0,
                                  4'h2, 4'h2, 4'h2, 4'h2, 4'h0,
                                  4'h4, 4'h4, 4'h4, 4'h4, 4'h0,
                                  4'h8, 4'h8, 4'h8, 4'h8, 4'h0, 4'h1};
    logic       single_vld [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0,
                                    1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic       bp_pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    initial begin
        din_a = 8'h11; din_b = 8'h22; din_c = 8'h33; din_d = 8'h44;

        // Reset held with no clock edges at all.
        #1;
        rst = 1'b1;
        req = 4'b1111;
        #1;
        check("rst_grant", {28'b0, grant}, 32'd0);
        check("rst_sel",   {30'b0, sel},   32'd0);
        check("rst_vld",   {31'b0, dout_vld}, 32'd0);
        check("rst_dout",  {24'b0, dout},  32'h11);
        #3;
        rst     = 1'b0;
        req     = 4'b0;
        clk_run = 1'b1;
        chk_en  = 1'b1;

        // Fairness with everyone requesting.
        reset_dut();
        req = 4'b1111;
        out_rdy = 1'b1;
        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            check("fair_grant", {28'b0, grant}, {28'b0, fair_exp[i]});
        end

        // Single requester.
        reset_dut();
        req = 4'b0100;
        din_c = 8'hA5;
        out_rdy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("single_vld", {31'b0, dout_vld}, {31'b0, single_vld[i]});
            if (single_vld[i]) begin
                check("single_sel",  {30'b0, sel},  32'd2);
                check("single_dout", {24'b0, dout}, 32'hA5);
            end
        end

        // Backpressure: accepts only on out_rdy=1 cycles, grant held throughout.
        reset_dut();
        req = 4'b0001;
        @(posedge clk);
        for (int i = 0; i < 6; i++) begin
            #2;
            out_rdy = bp_pat[i];
            @(negedge clk);
            check("bp_accept", {31'b0, dout_vld & out_rdy}, {31'b0, bp_pat[i]});
            check("bp_grant",  {28'b0, grant}, 32'h1);
            @(posedge clk);
        end
        #2;
        out_rdy = 1'b1;
        @(negedge clk);
        check("bp_release", {28'b0, grant}, 32'h0);

        // Early drop of the granted request after two beats.
        reset_dut();
        req = 4'b1100;
        out_rdy = 1'b1;
        @(negedge clk);
        check("drop_grant", {28'b0, grant}, 32'h4);
        @(negedge clk);
        check("drop_vld2", {31'b0, dout_vld}, 32'd1);
        @(posedge clk);
        #2;
        req = 4'b1000;
        @(negedge clk);
        check("drop_vld0", {31'b0, dout_vld}, 32'd0);
        @(negedge clk);
        check("drop_rel", {28'b0, grant}, 32'h0);
        @(negedge clk);
        check("drop_next", {28'b0, grant}, 32'h8);

        // Asynchronous reset during requester 3's burst.
        reset_dut();
        req = 4'b1111;
        out_rdy = 1'b1;
        repeat (17) @(posedge clk);
        #2;
        check("mid_pre", {28'b0, grant}, 32'h8);
        rst = 1'b1;
        #1;
        check("mid_grant", {28'b0, grant}, 32'h0);
        check("mid_sel",   {30'b0, sel},   32'd0);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_idle", {28'b0, grant}, 32'h0);
        @(negedge clk);
        check("mid_first", {28'b0, grant}, 32'h1);

        // Random traffic against the model.
        reset_dut();
        repeat (3000) begin
            @(posedge clk);
            #2;
            if ($urandom_range(0, 3) == 0) req = 4'($urandom);
            out_rdy = ($urandom_range(0, 3) != 0);
            din_a = 8'($urandom);
            din_b = 8'($urandom);
            din_c = 8'($urandom);
            din_d = 8'($urandom);
            if ($urandom_range(0, 199) == 0) begin
                rst = 1'b1;
                #1;
                rst = 1'b0;
            end
        end
        @(negedge clk);
        chk_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
